// File: rtl/btb_update_ctrl_pkg.sv
// Shared BTB types: array entry layout and write-side controller state encoding.
package btb_update_ctrl_pkg;

    localparam int unsigned TABLE_ENTRIES = 64;
    localparam int unsigned INDEX_WIDTH   = $clog2(TABLE_ENTRIES);
    localparam int unsigned TAG_WIDTH     = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        BTB_ETYPE_BRANCH,
        BTB_ETYPE_JAL,
        BTB_ETYPE_JALR,
        BTB_ETYPE_RET
    } btb_etype_t;

    typedef struct packed {
        logic                 valid;
        btb_etype_t           etype;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    typedef enum logic [1:0] {
        BTBC_INIT,
        BTBC_SWEEP,
        BTBC_RUN
    } btb_ctrl_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small update queue for BTB writes; the tail slot can be rewritten in place so repeated
// updates to the same index collapse into one write.
module btb_upd_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = INDEX_WIDTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             coalesce_i,
    input  logic             pop_i,
    input  logic [IDX_W-1:0] idx_i,
    input  btb_entry_t       entry_i,
    output logic [IDX_W-1:0] head_idx_o,
    output btb_entry_t       head_entry_o,
    output logic [IDX_W-1:0] tail_idx_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [IDX_W-1:0] idx_q   [DEPTH];
    btb_entry_t       entry_q [DEPTH];

    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PtrW-1:0]  tail_ptr;

    assign tail_ptr = wptr_q - 1'b1;

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_i) begin
            idx_q[wptr_q]   <= idx_i;
            entry_q[wptr_q] <= entry_i;
        end else if (coalesce_i) begin
            idx_q[tail_ptr]   <= idx_i;
            entry_q[tail_ptr] <= entry_i;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head_idx_o   = idx_q[rptr_q];
    assign head_entry_o = entry_q[rptr_q];
    assign tail_idx_o   = idx_q[tail_ptr];
    assign count_o      = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port owner: invalidation sweep after reset/flush, then drains queued EX updates
// one per cycle. Prediction is masked until the sweep has finished.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES    = TABLE_ENTRIES,
    parameter int unsigned IDX_W      = $clog2(ENTRIES),
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  btb_entry_t       upd_entry,
    output logic             upd_ready,
    input  logic             flush_req,
    input  logic             wr_hold,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_index,
    output btb_entry_t       wr_entry,
    output logic             pred_enable,
    output logic             flush_busy,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    btb_ctrl_state_t  state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [15:0]      drop_q, drop_d;

    logic             accept;
    logic             do_pop;
    logic             coalesce;
    logic             push;
    logic             fifo_clr;
    logic             fifo_empty;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    btb_entry_t       head_entry;
    logic [CntW-1:0]  fifo_count;

    // Readiness comes from registered state only, so EX never sees a path from hold/valid.
    assign upd_ready  = (state_q == BTBC_RUN) && (fifo_count < CntW'(FIFO_DEPTH));
    assign accept     = upd_valid && upd_ready && !flush_req;
    assign fifo_empty = (fifo_count == '0);
    assign do_pop     = (state_q == BTBC_RUN) && !fifo_empty && !wr_hold;
    assign fifo_clr   = (state_q == BTBC_RUN) && flush_req;

    // A lone entry that is leaving this cycle cannot absorb the new update.
    assign coalesce = accept && !fifo_empty && (tail_idx == upd_index)
                      && !((fifo_count == CntW'(1)) && do_pop);
    assign push     = accept && !coalesce;

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CntW)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (fifo_clr),
        .push_i       (push),
        .coalesce_i   (coalesce),
        .pop_i        (do_pop),
        .idx_i        (upd_index),
        .entry_i      (upd_entry),
        .head_idx_o   (head_idx),
        .head_entry_o (head_entry),
        .tail_idx_o   (tail_idx),
        .count_o      (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BTBC_INIT;
            sweep_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            BTBC_INIT: begin
                state_d = BTBC_SWEEP;
                sweep_d = '0;
            end
            BTBC_SWEEP: begin
                if (flush_req) begin
                    sweep_d = '0;
                end else if (!wr_hold) begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = BTBC_RUN;
                end
            end
            BTBC_RUN: begin
                if (flush_req) begin
                    state_d = BTBC_SWEEP;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = BTBC_INIT;
                sweep_d = '0;
            end
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (upd_valid && !accept && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_index    = '0;
        wr_entry    = '0;
        pred_enable = 1'b0;
        flush_busy  = 1'b1;
        unique case (state_q)
            BTBC_SWEEP: begin
                wr_en    = !wr_hold;
                wr_index = sweep_q;
            end
            BTBC_RUN: begin
                wr_en       = do_pop;
                wr_index    = head_idx;
                wr_entry    = head_entry;
                pred_enable = 1'b1;
                flush_busy  = 1'b0;
            end
            default: ;
        endcase
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: table of RUN-mode cycles plus sweep/flush/reset sequences.
module tb_btb_update_ctrl;
    import btb_update_ctrl_pkg::*;

    localparam int NENT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_index = '0;
    btb_entry_t  upd_entry = '0;
    logic        upd_ready;
    logic        flush_req = 1'b0;
    logic        wr_hold = 1'b0;
    logic        wr_en;
    logic [5:0]  wr_index;
    btb_entry_t  wr_entry;
    logic        pred_enable;
    logic        flush_busy;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_index   (upd_index),
        .upd_entry   (upd_entry),
        .upd_ready   (upd_ready),
        .flush_req   (flush_req),
        .wr_hold     (wr_hold),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_entry    (wr_entry),
        .pred_enable (pred_enable),
        .flush_busy  (flush_busy),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic        vld;
        logic [5:0]  idx;
        logic [31:0] tgt;
        logic        hold;
        logic        exp_en;
        logic [5:0]  exp_idx;
        logic [31:0] exp_tgt;
        logic        exp_rdy;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vq[$];

    function automatic btb_entry_t mk_entry(input logic [5:0] idx, input logic [31:0] tgt);
        btb_entry_t e;
        e.valid  = 1'b1;
        e.etype  = BTB_ETYPE_JAL;
        e.tag    = {18'h2a, idx};
        e.target = tgt;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic vld, input logic [5:0] idx, input logic [31:0] tgt,
                       input logic hold, input logic en, input logic [5:0] eidx,
                       input logic [31:0] etgt, input logic rdy, input logic [15:0] drp);
        vec_t v;
        v.vld = vld; v.idx = idx; v.tgt = tgt; v.hold = hold;
        v.exp_en = en; v.exp_idx = eidx; v.exp_tgt = etgt; v.exp_rdy = rdy; v.exp_drop = drp;
        vq.push_back(v);
    endtask

    // Called at a negedge with the DUT in SWEEP at counter 0; returns at the negedge after RUN.
    task automatic run_sweep(input int flush_at, input int hold_at, input int valid_at);
        int  i;
        bit  f, h, v, flushed, held, vdone;
        i = 0; flushed = 0; held = 0; vdone = 0;
        while (i < NENT) begin
            f = (i == flush_at) && !flushed;
            h = (i == hold_at) && !held;
            v = (i == valid_at) && !vdone;
            flush_req = f; wr_hold = h; upd_valid = v;
            upd_index = 6'd33; upd_entry = mk_entry(6'd33, 32'hdead);
            if (v) begin exp_drop++; vdone = 1; end
            #1;
            chk("sweep_wr_en", 64'(wr_en), 64'(!h));
            chk("sweep_wr_index", 64'(wr_index), 64'(i));
            chk("sweep_wr_entry", 64'(wr_entry), 64'(0));
            chk("sweep_pred_enable", 64'(pred_enable), 64'(0));
            chk("sweep_flush_busy", 64'(flush_busy), 64'(1));
            chk("sweep_upd_ready", 64'(upd_ready), 64'(0));
            @(negedge clk);
            flush_req = 1'b0; wr_hold = 1'b0; upd_valid = 1'b0;
            if (f) begin
                flushed = 1; i = 0;
            end else if (h) begin
                held = 1;
            end else begin
                i++;
            end
        end
        #1;
        chk("run_pred_enable", 64'(pred_enable), 64'(1));
        chk("run_flush_busy", 64'(flush_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_upd_ready", 64'(upd_ready), 64'(0));
        chk("rst_pred_enable", 64'(pred_enable), 64'(0));
        chk("rst_flush_busy", 64'(flush_busy), 64'(1));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("rst_wr_entry", 64'(wr_entry), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_wr_en", 64'(wr_en), 64'(0));
        chk("init_flush_busy", 64'(flush_busy), 64'(1));
        @(negedge clk);
        run_sweep(-1, -1, -1);

        // RUN-mode cycle table
        add(1, 6'd5,  32'h5005, 0, 0, 6'd0,  32'h0,    1, 0);
        add(0, 6'd0,  32'h0,    0, 1, 6'd5,  32'h5005, 1, 0);
        add(0, 6'd0,  32'h0,    0, 0, 6'd0,  32'h0,    1, 0);
        add(1, 6'd1,  32'h1001, 1, 0, 6'd0,  32'h0,    1, 0);
        add(1, 6'd2,  32'h2002, 1, 0, 6'd0,  32'h0,    1, 0);
        add(1, 6'd3,  32'h3003, 1, 0, 6'd0,  32'h0,    1, 0);
        add(1, 6'd4,  32'h4004, 1, 0, 6'd0,  32'h0,    1, 0);
        add(1, 6'd7,  32'h7007, 1, 0, 6'd0,  32'h0,    0, 0);
        add(0, 6'd0,  32'h0,    0, 1, 6'd1,  32'h1001, 0, 1);
        add(0, 6'd0,  32'h0,    0, 1, 6'd2,  32'h2002, 1, 1);
        add(0, 6'd0,  32'h0,    0, 1, 6'd3,  32'h3003, 1, 1);
        add(0, 6'd0,  32'h0,    0, 1, 6'd4,  32'h4004, 1, 1);
        add(0, 6'd0,  32'h0,    0, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd9,  32'hb001, 1, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd9,  32'hb002, 1, 0, 6'd0,  32'h0,    1, 1);
        add(0, 6'd0,  32'h0,    0, 1, 6'd9,  32'hb002, 1, 1);
        add(0, 6'd0,  32'h0,    0, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd10, 32'hc001, 0, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd10, 32'hc002, 0, 1, 6'd10, 32'hc001, 1, 1);
        add(0, 6'd0,  32'h0,    0, 1, 6'd10, 32'hc002, 1, 1);
        add(0, 6'd0,  32'h0,    0, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd11, 32'hd001, 1, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd12, 32'he001, 1, 0, 6'd0,  32'h0,    1, 1);
        add(1, 6'd12, 32'he002, 0, 1, 6'd11, 32'hd001, 1, 1);
        add(0, 6'd0,  32'h0,    0, 1, 6'd12, 32'he002, 1, 1);
        add(0, 6'd0,  32'h0,    0, 0, 6'd0,  32'h0,    1, 1);

        foreach (vq[k]) begin
            upd_valid = vq[k].vld;
            upd_index = vq[k].idx;
            upd_entry = mk_entry(vq[k].idx, vq[k].tgt);
            wr_hold   = vq[k].hold;
            #1;
            chk("vec_wr_en", 64'(wr_en), 64'(vq[k].exp_en));
            chk("vec_upd_ready", 64'(upd_ready), 64'(vq[k].exp_rdy));
            chk("vec_drop_cnt", 64'(drop_cnt), 64'(vq[k].exp_drop));
            chk("vec_pred_enable", 64'(pred_enable), 64'(1));
            if (vq[k].exp_en) begin
                chk("vec_wr_index", 64'(wr_index), 64'(vq[k].exp_idx));
                chk("vec_wr_entry", 64'(wr_entry), 64'(mk_entry(vq[k].exp_idx, vq[k].exp_tgt)));
            end
            @(negedge clk);
        end
        upd_valid = 1'b0; wr_hold = 1'b0;
        exp_drop = 1;

        // Flush in RUN with three queued updates
        wr_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            upd_valid = 1'b1;
            upd_index = 6'(20 + k);
            upd_entry = mk_entry(6'(20 + k), 32'(32'h2000 + k));
            @(negedge clk);
        end
        upd_valid = 1'b0;
        flush_req = 1'b1;
        #1;
        chk("preflush_pred_enable", 64'(pred_enable), 64'(1));
        @(negedge clk);
        flush_req = 1'b0; wr_hold = 1'b0;
        run_sweep(-1, 10, 3);
        chk("postflush_wr_en", 64'(wr_en), 64'(0));
        chk("postflush_upd_ready", 64'(upd_ready), 64'(1));
        chk("postflush_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        // Flush with a same-cycle update, then a second flush mid-sweep at index 40
        upd_valid = 1'b1; flush_req = 1'b1;
        upd_index = 6'd2; upd_entry = mk_entry(6'd2, 32'h2222);
        exp_drop++;
        @(negedge clk);
        upd_valid = 1'b0; flush_req = 1'b0;
        run_sweep(40, -1, -1);
        chk("restart_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("restart_wr_en", 64'(wr_en), 64'(0));

        // Asynchronous reset in the middle of a drain
        wr_hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            upd_valid = 1'b1;
            upd_index = 6'(40 + k);
            upd_entry = mk_entry(6'(40 + k), 32'h4444);
            @(negedge clk);
        end
        upd_valid = 1'b0; wr_hold = 1'b0;
        #1;
        chk("drain_wr_en", 64'(wr_en), 64'(1));
        chk("drain_wr_index", 64'(wr_index), 64'(40));
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 64'(wr_en), 64'(0));
        chk("arst_flush_busy", 64'(flush_busy), 64'(1));
        chk("arst_pred_enable", 64'(pred_enable), 64'(0));
        chk("arst_upd_ready", 64'(upd_ready), 64'(0));
        chk("arst_drop_cnt", 64'(drop_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller for the branch target buffer array. It owns the array's single write port.
- Sweeps every entry to invalid after reset and on a flush request (fence.i or context change).
- Buffers taken control-flow updates from EX in a small coalescing FIFO and drains them into the array one per cycle.
- Masks prediction hits while the array contents are not yet trustworthy.

Parameters:
- ENTRIES, default TABLE_ENTRIES (64): number of BTB entries; power of 2.
- IDX_W, default $clog2(ENTRIES): index width; must equal INDEX_WIDTH.
- FIFO_DEPTH, default 4: update queue depth; power of 2, at least 2.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- upd_valid  in  1: EX offers a taken branch/jump update this cycle.
- upd_index  in  IDX_W: target array index (pc_e[2 +: IDX_W]).
- upd_entry  in  btb_entry_t: entry to write (valid, etype, tag, target).
- upd_ready  out  1: an update offered this cycle will be accepted.
- flush_req  in  1: single-cycle pulse requesting invalidation of all entries.
- wr_hold  in  1: array write port unavailable this cycle.
- wr_en  out  1: array write enable.
- wr_index  out  IDX_W: array write index.
- wr_entry  out  btb_entry_t: array write data.
- pred_enable  out  1: 0 means btb_hit must be forced to 0 by the consumer.
- flush_busy  out  1: a sweep is pending or in progress.
- drop_cnt  out  16: saturating count of offered updates that were not accepted.

Behaviour:
- States: INIT, SWEEP, RUN. Reset state is INIT.
- Reset values: state INIT, sweep counter 0, FIFO empty, drop_cnt 0.
- Outputs during reset and in INIT: wr_en=0, wr_index=0, wr_entry='0, upd_ready=0, pred_enable=0, flush_busy=1.
- INIT -> SWEEP unconditionally on the next edge.
- SWEEP:
  - wr_en = !wr_hold, wr_index = sweep counter, wr_entry = '0.
  - The counter increments only on cycles where wr_hold=0.
  - After the write of index ENTRIES-1 completes, go to RUN.
  - Out of reset with no hold, RUN is entered ENTRIES+1 edges after reset release.
  - upd_ready=0, pred_enable=0, flush_busy=1.
- RUN:
  - pred_enable=1, flush_busy=0.
  - upd_ready = (count < FIFO_DEPTH). It depends on registered state only, with no combinational path from upd_valid or wr_hold.
  - wr_en = FIFO non-empty && !wr_hold; wr_index and wr_entry come from the FIFO head; a pop occurs when wr_en=1.
  - Latency: an update accepted at edge N, with an empty FIFO and no hold, is written at edge N+1 (wr_en high during cycle N+1).
- Coalescing:
  - An accepted update whose index equals the tail entry's index overwrites that tail entry instead of pushing a new one.
  - It does not coalesce when the tail is also the head being popped this cycle; it pushes instead.
  - The youngest data always wins.
- Simultaneous push and pop: count is unchanged. A full FIFO with a pop in the same cycle still reports upd_ready=0, because readiness is evaluated from registered count.
- Flush:
  - flush_req in RUN: go to SWEEP with counter 0 and empty the FIFO. Queued updates are discarded and not counted as drops.
  - flush_req in SWEEP, including the cycle of the final write: restart the counter at 0 and stay in SWEEP.
  - flush_req in INIT: no extra effect.
  - flush_req has priority over any same-cycle upd_valid.
- Drops:
  - drop_cnt increments on every cycle with upd_valid && !accepted.
  - This covers SWEEP, INIT, FIFO full, and a same-cycle flush.
  - drop_cnt saturates at 16'hFFFF and is cleared only by reset.
- Asynchronous reset asserted mid-sweep or mid-drain: all state returns to the reset values immediately, with no partial write guarantee beyond the current cycle.
- The counter and FIFO pointers wrap modulo their power-of-2 ranges; count is IDX-independent, $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- riscv_defines additions: btb_ctrl_state_t enum {BTBC_INIT, BTBC_SWEEP, BTBC_RUN}.
- Reuse btb_entry_t, TABLE_ENTRIES, INDEX_WIDTH from riscv_defines.
- One sub-module: btb_upd_fifo. It is a parameterised FIFO with a tail-overwrite (coalesce) port, flush clear, and count output.
- The FSM, sweep counter, write mux and drop counter stay in btb_update_ctrl.

Test Plan:
- Release rst_n with wr_hold=0, ENTRIES=64: wr_en with index 0..63 and wr_entry='0 on 64 consecutive cycles; pred_enable rises on edge 65.
- In RUN, upd_valid with index 5 at edge N: wr_en=1, wr_index=5, wr_entry=upd_entry during cycle N+1; FIFO empty afterwards.
- Hold wr_hold=1 and offer indices 1,2,3,4,7: the first four are accepted, then upd_ready=0 and the fifth is dropped, drop_cnt=1; release hold: writes 1,2,3,4 in order.
- With wr_hold=1, offer index 9 (target A) then index 9 (target B): one queued entry; after release a single write of index 9 with target B.
- Pulse flush_req in RUN with 3 entries queued: queue discarded, drop_cnt unchanged, full 64-entry sweep, pred_enable=0 until it completes.
- Pulse flush_req during sweep at index 40: sweep restarts at index 0 and needs 64 further writes before RUN.
